// File: rtl/dmem_req_pkg.sv
// Shared types and defaults for the data-memory request unit.
package dmem_req_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    SCFAIL = 2'd3
  } state_t;

endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation: one valid/address pair, set by a completed LL,
// cleared by a completed SC, by a completed plain store to the linked
// address, or by a snooped write to the linked address.
module llsc_link
  import dmem_req_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic              wr_done,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_match
);

  logic              valid;
  logic [ADDR_W-1:0] addr;

  assign chk_match = valid && (addr == chk_addr);

  // A snoop hitting the LL address in its completion cycle suppresses the set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (set && !(snoop_inv && (snoop_addr == set_addr))) begin
      valid <= 1'b1;
      addr  <= set_addr;
    end else if (clr || (wr_done && (wr_addr == addr)) ||
                 (snoop_inv && (snoop_addr == addr))) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_request_unit.sv
// Data-memory request unit: latches a load/store when the pipeline advances,
// holds the request until dhit, returns load data with a one-cycle dvalid,
// and raises sticky err/timeout flags.
// Optional LL/SC support is built when the LLSC_EN macro is defined.
module dmem_request_unit
  import dmem_req_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dload,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] drdata,
  output logic              dvalid,
  output logic              stall,
  output logic              err,
  output logic              timeout
);

  // With TIMEOUT_CYC = 0 the derived width is zero; keep one bit so the
  // counter stays legal (it never advances in that case).
  localparam int unsigned CW = (CNT_W == 0) ? 1 : CNT_W;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);
  localparam logic [DATA_W-1:0] SC_OK = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_next;

  assign stall    = (state != IDLE);
  assign cnt_next = wait_cnt + 1'b1;

`ifdef LLSC_EN
  logic is_ll;
  logic is_sc;
  logic sc_ok;

  llsc_link #(.ADDR_W(ADDR_W)) u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .set       ((state == READ) && dhit && is_ll),
    .set_addr  (dmemaddr),
    .clr       ((state == WRITE) && dhit && is_sc),
    .wr_done   ((state == WRITE) && dhit && !is_sc),
    .wr_addr   (dmemaddr),
    .snoop_inv (snoop_inv),
    .snoop_addr(snoop_addr),
    .chk_addr  (daddr),
    .chk_match (sc_ok)
  );
`else
  logic unused_llsc;
  assign unused_llsc = ^{datomic, snoop_inv, snoop_addr};
`endif

  // Request FSM: acceptance, hold-until-dhit, completion pulse, wait counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      drdata    <= '0;
      dvalid    <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
`ifdef LLSC_EN
      is_ll     <= 1'b0;
      is_sc     <= 1'b0;
`endif
    end else begin
      dvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ihit && (dREN || dWEN)) begin
            dmemaddr  <= daddr;
            dmemstore <= dstore;
            wait_cnt  <= '0;
            if (dREN) begin
              state   <= READ;
              dmemREN <= 1'b1;
              if (dWEN) err <= 1'b1;
`ifdef LLSC_EN
              is_ll   <= datomic;
              is_sc   <= 1'b0;
`endif
            end else begin
`ifdef LLSC_EN
              is_ll <= 1'b0;
              is_sc <= datomic;
              if (datomic && !sc_ok) begin
                state <= SCFAIL;
              end else begin
                state   <= WRITE;
                dmemWEN <= 1'b1;
              end
`else
              state   <= WRITE;
              dmemWEN <= 1'b1;
`endif
            end
          end
        end
        READ, WRITE: begin
          if (dhit) begin
            state   <= IDLE;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            dvalid  <= 1'b1;
            if (state == READ) drdata <= dload;
`ifdef LLSC_EN
            else if (is_sc) drdata <= SC_OK;
`endif
          end else begin
            if (wait_cnt != TMAX) wait_cnt <= cnt_next;
            if ((TIMEOUT_CYC != 0) && (wait_cnt != TMAX) && (cnt_next == TMAX))
              timeout <= 1'b1;
          end
        end
        SCFAIL: begin
          state  <= IDLE;
          dvalid <= 1'b1;
          drdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_request_unit.sv
// Self-checking bench for dmem_request_unit (TIMEOUT_CYC overridden to 4).
// Completion data is checked through a scoreboard queue; LL/SC scenarios
// are compiled only when LLSC_EN is defined.
module tb_dmem_request_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dREN, dWEN, datomic, dhit, snoop_inv;
  logic [AW-1:0] daddr, snoop_addr;
  logic [DW-1:0] dstore, dload;
  logic          dmemREN, dmemWEN, dvalid, stall, err, timeout;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore, drdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_rd;

  dmem_request_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dREN(dREN), .dWEN(dWEN),
    .datomic(datomic), .daddr(daddr), .dstore(dstore), .dhit(dhit),
    .dload(dload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .drdata(drdata), .dvalid(dvalid), .stall(stall),
    .err(err), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every dvalid pops one expected drdata.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && dvalid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_dvalid: got dvalid=1 with drdata=%h, required no completion", drdata);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (drdata !== exp) begin
          n_fail++;
          $display("FAIL sb_drdata: got %h required %h", drdata, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ihit = 0; dREN = 0; dWEN = 0; datomic = 0; dhit = 0; snoop_inv = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    daddr = '0; dstore = '0; dload = '0; snoop_addr = '0;
    nRST = 0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({dmemREN, dmemWEN, dvalid, stall, err, timeout} !== 6'b0 ||
        dmemaddr !== '0 || dmemstore !== '0 || drdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ren=%b wen=%b v=%b st=%b err=%b to=%b addr=%h st=%h rd=%h required all zero",
               dmemREN, dmemWEN, dvalid, stall, err, timeout, dmemaddr, dmemstore, drdata);
    end
    nRST = 1;
    last_rd = '0;
    @(negedge CLK);
  endtask

  task automatic test_load();
    ihit = 1; dREN = 1; daddr = 32'h40;
    sb.push_back(32'hDEAD_BEEF);
    last_rd = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ihit = 0; dREN = 0; daddr = 32'hFFFF_FFF0;
      n_checks++;
      if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h40 || stall !== 1'b1) begin
        n_fail++;
        $display("FAIL load_hold[%0d]: got ren=%b wen=%b addr=%h stall=%b required ren=1 wen=0 addr=00000040 stall=1",
                 i, dmemREN, dmemWEN, dmemaddr, stall);
      end
      if (i == 2) begin dhit = 1; dload = 32'hDEAD_BEEF; end
    end
    @(negedge CLK);
    dhit = 0; dload = '0;
    n_checks++;
    if (dmemREN !== 1'b0 || dvalid !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: got ren=%b dvalid=%b stall=%b required 0 1 0", dmemREN, dvalid, stall);
    end
    @(negedge CLK);
    n_checks++;
    if (dvalid !== 1'b0 || drdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_pulse: got dvalid=%b drdata=%h required 0 deadbeef", dvalid, drdata);
    end
  endtask

  task automatic test_store_no_ihit();
    ihit = 0; dWEN = 1; dstore = 32'h1234; daddr = 32'h80;
    repeat (2) begin
      @(negedge CLK);
      n_checks++;
      if (dmemWEN !== 1'b0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL store_ignored: got wen=%b stall=%b required 0 0", dmemWEN, stall);
      end
    end
    ihit = 1;
    sb.push_back(last_rd);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      ihit = 0; dWEN = 0; dstore = 32'h9999;
      n_checks++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'h1234 || dmemaddr !== 32'h80) begin
        n_fail++;
        $display("FAIL store_hold[%0d]: got wen=%b ren=%b store=%h addr=%h required 1 0 00001234 00000080",
                 i, dmemWEN, dmemREN, dmemstore, dmemaddr);
      end
      if (i == 1) begin dhit = 1; dload = 32'h5555_AAAA; end
    end
    @(negedge CLK);
    dhit = 0;
    n_checks++;
    if (dmemWEN !== 1'b0 || dvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL store_done: got wen=%b dvalid=%b required 0 1", dmemWEN, dvalid);
    end
    @(negedge CLK);
  endtask

  task automatic test_both_enables();
    ihit = 1; dREN = 1; dWEN = 1; daddr = 32'hC0; dstore = 32'h55;
    sb.push_back(32'hCAFE_0001);
    last_rd = 32'hCAFE_0001;
    @(negedge CLK);
    idle_inputs();
    n_checks++;
    if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL both_accept: got ren=%b wen=%b err=%b required 1 0 1", dmemREN, dmemWEN, err);
    end
    dhit = 1; dload = 32'hCAFE_0001;
    @(negedge CLK);
    dhit = 0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (err !== 1'b1 || dmemWEN !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL both_sticky: got err=%b wen=%b stall=%b required 1 0 0", err, dmemWEN, stall);
    end
  endtask

  task automatic test_reset_mid_access();
    ihit = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hABCD;
    @(negedge CLK);
    idle_inputs();
    n_checks++;
    if (dmemWEN !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got wen=%b required 1", dmemWEN);
    end
    #2 nRST = 0;
    #1;
    n_checks++;
    if ({dmemREN, dmemWEN, dvalid, stall, err, timeout} !== 6'b0 ||
        dmemaddr !== '0 || dmemstore !== '0 || drdata !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got ren=%b wen=%b v=%b st=%b err=%b to=%b addr=%h store=%h rd=%h required all zero",
               dmemREN, dmemWEN, dvalid, stall, err, timeout, dmemaddr, dmemstore, drdata);
    end
    @(negedge CLK);
    nRST = 1;
    last_rd = '0;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    ihit = 1; dREN = 1; daddr = 32'h300;
    sb.push_back(32'h0BAD_F00D);
    last_rd = 32'h0BAD_F00D;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      idle_inputs();
      if (k >= 2) begin
        n_checks++;
        if (timeout !== (k - 1 >= 4) || dmemREN !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_wait[%0d]: got timeout=%b ren=%b required %b 1", k - 1, timeout, dmemREN, (k - 1 >= 4));
        end
      end
    end
    dhit = 1; dload = 32'h0BAD_F00D;
    @(negedge CLK);
    dhit = 0;
    n_checks++;
    if (dmemREN !== 1'b0 || dvalid !== 1'b1 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_done: got ren=%b dvalid=%b timeout=%b required 0 1 1", dmemREN, dvalid, timeout);
    end
    @(negedge CLK);
    nRST = 0;
    @(negedge CLK);
    nRST = 1;
    last_rd = '0;
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b required 0", timeout);
    end
  endtask

  task automatic test_back_to_back();
    // Two loads: the second is accepted in the cycle right after dvalid.
    ihit = 1; dREN = 1; daddr = 32'h500;
    sb.push_back(32'h0000_0501);
    @(negedge CLK);
    idle_inputs();
    dhit = 1; dload = 32'h0000_0501;
    ihit = 1; dREN = 1; daddr = 32'h600;
    @(negedge CLK);
    dhit = 0;
    n_checks++;
    if (dmemREN !== 1'b0 || dvalid !== 1'b1 || dmemaddr !== 32'h500) begin
      n_fail++;
      $display("FAIL b2b_gap: got ren=%b dvalid=%b addr=%h required 0 1 00000500", dmemREN, dvalid, dmemaddr);
    end
    sb.push_back(32'h0000_0601);
    last_rd = 32'h0000_0601;
    @(negedge CLK);
    idle_inputs();
    n_checks++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h600) begin
      n_fail++;
      $display("FAIL b2b_second: got ren=%b addr=%h required 1 00000600", dmemREN, dmemaddr);
    end
    dhit = 1; dload = 32'h0000_0601;
    @(negedge CLK);
    dhit = 0;
    @(negedge CLK);
  endtask

`ifdef LLSC_EN
  task automatic test_llsc();
    // LL 0x100 then SC 0x100: succeeds.
    ihit = 1; dREN = 1; datomic = 1; daddr = 32'h100;
    sb.push_back(32'h0000_0011);
    @(negedge CLK);
    idle_inputs();
    dhit = 1; dload = 32'h0000_0011;
    @(negedge CLK);
    dhit = 0;
    @(negedge CLK);
    ihit = 1; dWEN = 1; datomic = 1; daddr = 32'h100; dstore = 32'h77;
    sb.push_back(32'h1);
    @(negedge CLK);
    idle_inputs();
    n_checks++;
    if (dmemWEN !== 1'b1) begin
      n_fail++;
      $display("FAIL sc_ok_wen: got %b required 1", dmemWEN);
    end
    dhit = 1;
    @(negedge CLK);
    dhit = 0;
    @(negedge CLK);
    // LL 0x100, snoop 0x100, SC 0x100: fails without a memory access.
    ihit = 1; dREN = 1; datomic = 1; daddr = 32'h100;
    sb.push_back(32'h0000_0022);
    @(negedge CLK);
    idle_inputs();
    dhit = 1; dload = 32'h0000_0022;
    @(negedge CLK);
    dhit = 0;
    snoop_inv = 1; snoop_addr = 32'h100;
    @(negedge CLK);
    snoop_inv = 0;
    ihit = 1; dWEN = 1; datomic = 1; daddr = 32'h100;
    sb.push_back(32'h0);
    @(negedge CLK);
    idle_inputs();
    n_checks++;
    if (dmemWEN !== 1'b0 || stall !== 1'b1 || dvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_fail_state: got wen=%b stall=%b dvalid=%b required 0 1 0", dmemWEN, stall, dvalid);
    end
    @(negedge CLK);
    n_checks++;
    if (dvalid !== 1'b1 || drdata !== '0 || dmemWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_fail_done: got dvalid=%b drdata=%h wen=%b required 1 0 0", dvalid, drdata, dmemWEN);
    end
    @(negedge CLK);
    last_rd = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store_no_ihit();
    test_both_enables();
    test_reset_mid_access();
    test_back_to_back();
    test_timeout();
`ifdef LLSC_EN
    test_llsc();
`endif
    repeat (2) @(negedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending completions required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
